fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_ctrl_fwd_sel.sv | 45 ++++
 rtl/fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types and constants for the fetch/hazard controller.
//   state_t            : controller FSM states (BOOT, RUN, LDBUB, REDIR)
//   FWD_RF/FWD_WB/FWD_MEM : ALU operand-select codes driven on ForwardAE/BE
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,   // first cycle after reset, IMem output not valid yet
      RUN   = 2'd1,   // normal operation
      LDBUB = 2'd2,   // cycle after a load-use stall, bubble moving to Execute
      REDIR = 2'd3    // cycle after a redirect, IMem still returning old PC
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fetch_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Per-operand register compare: one instance per ALU source operand.
//   rs_d          : source register of the Decode instruction (hazard check)
//   rs_e          : source register of the Execute instruction (forwarding)
//   rd_e/rd_m/rd_w: destination registers in Execute/Memory/Writeback
//   reg_write_*   : destination-write enables for those stages
//   hit_e, hit_m  : rs_d matches the Execute / Memory destination
//   fwd           : operand select, Memory result preferred over Writeback
// A match needs the stage's write enable and a non-zero destination; R0 is
// hard-wired and never produces a hazard or a forward.
// -----------------------------------------------------------------------------
module fwd_sel
   import fetch_ctrl_pkg::*;
#(
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rs_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_e,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   output logic              hit_e,
   output logic              hit_m,
   output logic [1:0]        fwd
);

   logic fwd_hit_m;
   logic fwd_hit_w;

   assign hit_e     = reg_write_e && (rd_e != '0) && (rd_e == rs_d);
   assign hit_m     = reg_write_m && (rd_m != '0) && (rd_m == rs_d);
   assign fwd_hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
   assign fwd_hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

   always_comb begin
      if (fwd_hit_m)      fwd = FWD_MEM;   // youngest result wins
      else if (fwd_hit_w) fwd = FWD_WB;
      else                fwd = FWD_RF;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Pipeline hazard and fetch controller for a 5-stage in-order core.
//   clk, rst            : clock; asynchronous active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E: source registers in Decode / Execute
//   RdE/RdM/RdW         : destination registers in Execute/Memory/Writeback
//   RegWriteE/M/W       : destination-write enables per stage
//   MemReadE            : Execute instruction is a load
//   PCSrcE              : taken branch / jump resolved in Execute
//   StallF/StallD       : hold PC / hold IF/ID
//   FlushD/FlushE       : bubble IF/ID / bubble ID/EX
//   ForwardAE/ForwardBE : ALU operand select (00 RF, 10 Memory, 01 Writeback)
//   stall_cnt/flush_cnt : saturating statistics (stall cycles / redirects)
// Build option FETCH_CTRL_FORWARD_EN:
//   defined   - forwarding active, only a load-use hazard stalls (then LDBUB).
//   undefined - forwarding tied to 00, any Decode RAW on Execute or Memory
//               stalls for as long as it persists; LDBUB is never entered.
// Control outputs are combinational from state and inputs; counters update on
// the following clock edge.
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int REG_AW = 4,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemReadE,
   input  logic              PCSrcE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt
);

   localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     state_nxt;
   logic       hit_e_a, hit_m_a, hit_e_b, hit_m_b;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_req;

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .rs_d        (Rs1D),
      .rs_e        (Rs1E),
      .rd_e        (RdE),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_e (RegWriteE),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .hit_e       (hit_e_a),
      .hit_m       (hit_m_a),
      .fwd         (fwd_a)
   );

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .rs_d        (Rs2D),
      .rs_e        (Rs2E),
      .rd_e        (RdE),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_e (RegWriteE),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .hit_e       (hit_e_b),
      .hit_m       (hit_m_b),
      .fwd         (fwd_b)
   );

`ifdef FETCH_CTRL_FORWARD_EN
   // Only a load in Execute cannot be forwarded in time; one bubble clears it.
   localparam state_t STALL_NEXT = LDBUB;
   logic unused_hit_m;

   assign stall_req    = MemReadE && (hit_e_a || hit_e_b);
   assign ForwardAE    = rst ? fwd_a : FWD_RF;
   assign ForwardBE    = rst ? fwd_b : FWD_RF;
   assign unused_hit_m = hit_m_a ^ hit_m_b;
`else
   // Without forwarding, hold Decode until the producer reaches Writeback;
   // the register file writes in the first half-cycle so Writeback is safe.
   localparam state_t STALL_NEXT = RUN;
   logic unused_fwd;

   assign stall_req  = hit_e_a || hit_e_b || hit_m_a || hit_m_b;
   assign ForwardAE  = FWD_RF;
   assign ForwardBE  = FWD_RF;
   assign unused_fwd = ^{fwd_a, fwd_b, MemReadE};
`endif

   // NOTE: every output of a combinational block gets a default before the
   // case statement, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      if (!rst) begin
         FlushD = 1'b1;                       // reset overrides the FSM
      end else begin
         unique case (state)
            BOOT: begin
               FlushD    = 1'b1;
               state_nxt = RUN;
            end
            RUN, LDBUB: begin
               state_nxt = RUN;
               if (PCSrcE) begin              // redirect beats any stall
                  FlushD    = 1'b1;
                  FlushE    = 1'b1;
                  state_nxt = REDIR;
               end else if (stall_req && state == RUN) begin
                  StallF    = 1'b1;
                  StallD    = 1'b1;
                  FlushE    = 1'b1;
                  state_nxt = STALL_NEXT;
               end
            end
            REDIR: begin
               FlushD    = 1'b1;
               FlushE    = PCSrcE;
               state_nxt = PCSrcE ? REDIR : RUN;
            end
            default: begin
               FlushD    = 1'b1;
               state_nxt = BOOT;
            end
         endcase
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (StallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
         if (PCSrcE && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl: a directed vector table, hand-written
// saturation and mid-operation reset sequences, then randomized cycles checked
// against a behavioural model. Inputs change 1 time unit after posedge; outputs
// are compared on negedge. Follows FETCH_CTRL_FORWARD_EN like the design.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam int SW      = 8;
   localparam int CNT_MAX = (1 << SW) - 1;
`ifdef FETCH_CTRL_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          RegWriteE, RegWriteM, RegWriteW, MemReadE, PCSrcE;
   logic          StallF, StallD, FlushD, FlushE;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [SW-1:0] stall_cnt, flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_ctrl #(.REG_AW(4), .STAT_W(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .Rs1D      (Rs1D),
      .Rs2D      (Rs2D),
      .Rs1E      (Rs1E),
      .Rs2E      (Rs2E),
      .RdE       (RdE),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteE (RegWriteE),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .MemReadE  (MemReadE),
      .PCSrcE    (PCSrcE),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   // ctl = {StallF, StallD, FlushD, FlushE}; en = {RegWriteE/M/W, MemReadE, PCSrcE}
   typedef struct {
      logic [3:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic [4:0] en;
      logic [3:0] ctl;
      logic [1:0] fa, fb;
      int         sc, fc;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(input logic [3:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                               input logic [4:0] en, input logic [3:0] ctl,
                               input logic [1:0] fa, fb, input int sc, fc);
      vec_t v;
      v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
      v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.en = en; v.ctl = ctl;
      v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc;
      return v;
   endfunction

   function automatic vec_t idle(input logic [3:0] ctl, input int sc, fc);
      return mk(0, 0, 0, 0, 0, 0, 0, 5'b00000, ctl, 2'b00, 2'b00, sc, fc);
   endfunction

   task automatic apply(input vec_t v);
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
      {RegWriteE, RegWriteM, RegWriteW, MemReadE, PCSrcE} = v.en;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] ctl_now();
      return {StallF, StallD, FlushD, FlushE};
   endfunction

   // ---------------- behavioural reference model ----------------
   bit         m_boot, m_redir, m_bubble;
   int         m_scnt, m_fcnt;
   logic [3:0] e_ctl;
   logic [1:0] e_fa, e_fb;

   function automatic bit hit(input logic [3:0] rs, rd, input logic we);
      return we && (rd != 0) && (rd == rs);
   endfunction

   function automatic logic [1:0] fwd_exp(input logic [3:0] rs);
      if (!FWD_ON || !rst)          return 2'b00;
      if (hit(rs, RdM, RegWriteM))  return 2'b10;
      if (hit(rs, RdW, RegWriteW))  return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit hazard_exp();
      bit e, m;
      e = hit(Rs1D, RdE, RegWriteE) || hit(Rs2D, RdE, RegWriteE);
      m = hit(Rs1D, RdM, RegWriteM) || hit(Rs2D, RdM, RegWriteM);
      return FWD_ON ? (MemReadE && e) : (e || m);
   endfunction

   task automatic model_reset();
      m_boot = 1; m_redir = 0; m_bubble = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic model_eval();
      e_fa = fwd_exp(Rs1E);
      e_fb = fwd_exp(Rs2E);
      if (!rst || m_boot)                     e_ctl = 4'b0010;
      else if (m_redir)                       e_ctl = {3'b001, PCSrcE};
      else if (PCSrcE)                        e_ctl = 4'b0011;
      else if (!m_bubble && hazard_exp())     e_ctl = 4'b1101;
      else                                    e_ctl = 4'b0000;
   endtask

   task automatic model_clock();
      if (!rst) return;
      if (e_ctl[2] && m_scnt < CNT_MAX) m_scnt++;
      if (PCSrcE && m_fcnt < CNT_MAX)   m_fcnt++;
      m_redir  = !m_boot && PCSrcE;
      m_bubble = FWD_ON && e_ctl[2];
      m_boot   = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vecs[0]  = idle(4'b0010, 0, 0);                       // BOOT
      vecs[1]  = idle(4'b0000, 0, 0);
      vecs[2]  = mk(3, 0, 0, 0, 3, 0, 0, 5'b10010, 4'b1101, 2'b00, 2'b00, 0, 0);
      vecs[3]  = idle(4'b0000, 1, 0);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 5'b00001, 4'b0011, 2'b00, 2'b00, 1, 0);
      vecs[5]  = idle(4'b0010, 1, 1);                       // REDIR
      vecs[6]  = idle(4'b0000, 1, 1);
      vecs[7]  = mk(3, 0, 0, 0, 3, 0, 0, 5'b10011, 4'b0011, 2'b00, 2'b00, 1, 1);
      vecs[8]  = idle(4'b0010, 1, 2);
      vecs[9]  = idle(4'b0000, 1, 2);
      vecs[10] = mk(0, 0, 5, 0, 0, 5, 5, 5'b01100, 4'b0000,
                    FWD_ON ? 2'b10 : 2'b00, 2'b00, 1, 2);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 5'b11110, 4'b0000, 2'b00, 2'b00, 1, 2);
      vecs[12] = mk(0, 0, 0, 7, 0, 7, 7, 5'b00100, 4'b0000,
                    2'b00, FWD_ON ? 2'b01 : 2'b00, 1, 2);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 5'b00001, 4'b0011, 2'b00, 2'b00, 1, 2);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 5'b00001, 4'b0011, 2'b00, 2'b00, 1, 3);
      vecs[15] = idle(4'b0010, 1, 4);
      vecs[16] = idle(4'b0000, 1, 4);
      vecs[17] = mk(0, 6, 0, 0, 6, 0, 0, 5'b10010, 4'b1101, 2'b00, 2'b00, 1, 4);
      vecs[18] = idle(4'b0000, 2, 4);
      vecs[19] = mk(4, 0, 0, 0, 0, 4, 0, 5'b01000,
                    FWD_ON ? 4'b0000 : 4'b1101, 2'b00, 2'b00, 2, 4);
      vecs[20] = idle(4'b0000, FWD_ON ? 2 : 3, 4);

      // Reset held with hazards and forward matches present on the inputs.
      rst = 1'b0;
      apply(mk(3, 0, 5, 0, 3, 5, 0, 5'b11011, 4'b0000, 2'b00, 2'b00, 0, 0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", ctl_now(), 4'b0010);
      check("reset_fwd", {ForwardAE, ForwardBE}, 4'b0000);
      check("reset_cnt", {stall_cnt, flush_cnt}, 0);

      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 21; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         apply(vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d_ctl", i), ctl_now(), vecs[i].ctl);
         check($sformatf("vec%0d_fa", i), ForwardAE, vecs[i].fa);
         check($sformatf("vec%0d_fb", i), ForwardBE, vecs[i].fb);
         check($sformatf("vec%0d_scnt", i), stall_cnt, vecs[i].sc);
         check($sformatf("vec%0d_fcnt", i), flush_cnt, vecs[i].fc);
      end

      // Hold a load-use hazard long enough to saturate stall_cnt.
      @(posedge clk); #1;
      apply(mk(3, 0, 0, 0, 3, 0, 0, 5'b10010, 4'b0000, 2'b00, 2'b00, 0, 0));
      repeat (FWD_ON ? 2 * (1 << SW) + 4 : (1 << SW) + 2) @(posedge clk);
      @(negedge clk);
      check("stall_sat", stall_cnt, CNT_MAX);
      @(posedge clk); #1; apply(idle(0, 0, 0));
      @(posedge clk); #1; apply(idle(0, 0, 0));
      @(posedge clk); #1;
      apply(mk(3, 0, 0, 0, 3, 0, 0, 5'b10010, 4'b0000, 2'b00, 2'b00, 0, 0));
      @(negedge clk);
      check("stall_hold_ctl", ctl_now(), 4'b1101);
      check("stall_sat_hold", stall_cnt, CNT_MAX);
      #1 rst = 1'b0;                                // mid-stall, no clock edge
      #1;
      check("rst_mid_stall_ctl", ctl_now(), 4'b0010);
      check("rst_mid_stall_cnt", {stall_cnt, flush_cnt}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      apply(idle(0, 0, 0));
      @(negedge clk);
      check("boot_after_stall", ctl_now(), 4'b0010);
      @(posedge clk); #1;
      @(negedge clk);
      check("no_bubble_after_boot", ctl_now(), 4'b0000);

      // Reset in the middle of a redirect.
      @(posedge clk); #1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 5'b00001, 4'b0000, 2'b00, 2'b00, 0, 0));
      @(negedge clk);
      check("redir_ctl", ctl_now(), 4'b0011);
      @(posedge clk); #1;
      apply(idle(0, 0, 0));
      @(negedge clk);
      check("redir_second", ctl_now(), 4'b0010);
      check("redir_fcnt", flush_cnt, 1);
      #1 rst = 1'b0;
      #1;
      check("rst_mid_redir_cnt", flush_cnt, 0);
      check("rst_mid_redir_ctl", ctl_now(), 4'b0010);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("boot_after_redir", ctl_now(), 4'b0010);
      @(posedge clk); #1;
      @(negedge clk);
      check("no_redir_after_boot", ctl_now(), 4'b0000);

      // Back-to-back redirects saturate flush_cnt.
      @(posedge clk); #1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 5'b00001, 4'b0000, 2'b00, 2'b00, 0, 0));
      repeat ((1 << SW) + 2) @(posedge clk);
      @(negedge clk);
      check("flush_sat", flush_cnt, CNT_MAX);
      check("flush_sat_ctl", ctl_now(), 4'b0011);

      // Randomized cycles against the model, with occasional resets.
      @(posedge clk); #1;
      rst = 1'b0;
      apply(idle(0, 0, 0));
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (c > 0) begin
            @(posedge clk);
            model_clock();
            #1;
            rst = ($urandom_range(0, 149) != 0);
            if (!rst) model_reset();
            Rs1D = 4'($urandom_range(0, 3)); Rs2D = 4'($urandom_range(0, 3));
            Rs1E = 4'($urandom_range(0, 3)); Rs2E = 4'($urandom_range(0, 3));
            RdE  = 4'($urandom_range(0, 3)); RdM  = 4'($urandom_range(0, 3));
            RdW  = 4'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemReadE  = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 7) == 0);
         end
         @(negedge clk);
         model_eval();
         check($sformatf("rnd%0d_ctl", c), ctl_now(), e_ctl);
         check($sformatf("rnd%0d_fwd", c), {ForwardAE, ForwardBE}, {e_fa, e_fb});
         check($sformatf("rnd%0d_scnt", c), stall_cnt, m_scnt);
         check($sformatf("rnd%0d_fcnt", c), flush_cnt, m_fcnt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
